// File: rtl/gzip_pkg.sv
// Shared constants, state/error types and keep helpers for the gzip member deframer.
package gzip_pkg;

    localparam logic [7:0] GZIP_ID1        = 8'h1F;
    localparam logic [7:0] GZIP_ID2        = 8'h8B;
    localparam logic [7:0] GZIP_CM_DEFLATE = 8'h08;
    localparam int         GZIP_HDR_BYTES  = 10;
    localparam int         GZIP_TRL_BYTES  = 8;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        BODY  = 2'd1,
        FLUSH = 2'd2,
        SKIP  = 2'd3
    } deframer_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_HDR = 2'd1,
        ERR_SHORT   = 2'd2
    } gzip_err_t;

    function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, keep[i]};
        end
        return n;
    endfunction

    // Contiguous low-aligned keep for n bytes, n in 1..8.
    function automatic logic [7:0] byte_mask(input logic [3:0] n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/gzip_member_deframer_if.sv
// AXI4-Stream bus bundle used on both sides of the gzip member deframer.
interface gzip_member_deframer_if #(
    parameter int DATA_BITS = 64
);
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport m (output tdata, tkeep, tlast, tvalid, input tready);
    modport s (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/gzip_byte_stager.sv
// Byte FIFO holding payload plus trailer; index 0 is the oldest byte.
// Supports pop-8 then append-1..8 in one cycle, and peeks of the oldest/newest 8 bytes.
module gzip_byte_stager
    import gzip_pkg::*;
#(
    parameter int CAP_BYTES = 24
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear_i,
    input  logic                             pop_i,
    input  logic                             push_i,
    input  logic [63:0]                      push_data_i,
    input  logic [7:0]                       push_keep_i,
    output logic [$clog2(CAP_BYTES+1)-1:0]   count_o,
    output logic [63:0]                      oldest_o,
    output logic [63:0]                      newest_o
);
    localparam int CW = $clog2(CAP_BYTES + 1);

    logic [CAP_BYTES*8-1:0] buf_q, buf_d, shifted, ins, mask;
    logic [CW-1:0]          count_q, count_d, base;
    logic [7:0]             push_mask;

    // Pop shifts everything down 8 bytes first; the append then lands after the survivors.
    always_comb begin
        shifted   = pop_i ? (buf_q >> 64) : buf_q;
        base      = pop_i ? (count_q - CW'(8)) : count_q;
        push_mask = push_i ? push_keep_i : 8'h00;
        mask      = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{push_mask[i]}};
        end
        mask    = mask << {base, 3'b000};
        ins     = {{((CAP_BYTES-8)*8){1'b0}}, push_data_i} << {base, 3'b000};
        buf_d   = (shifted & ~mask) | (ins & mask);
        count_d = base + (push_i ? CW'(keep_bytes(push_keep_i)) : '0);
        if (clear_i) begin
            buf_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign oldest_o = buf_q[63:0];
    assign newest_o = 64'(buf_q >> {count_q - CW'(8), 3'b000});

endmodule

// File: rtl/gzip_member_deframer.sv
// Strips gzip header/trailer from one member per packet and repacks DEFLATE into full beats.
// Optional GZIP_DEFRAMER_STATS_EN adds saturating member/error/payload-byte counters.
module gzip_member_deframer
    import gzip_pkg::*;
#(
    parameter int DATA_BITS = 64,
    parameter int CAP_BYTES = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    gzip_member_deframer_if.s        axis_snk,
    gzip_member_deframer_if.m        axis_src,
    output logic                     trl_valid,
    output logic [31:0]              trl_crc32,
    output logic [31:0]              trl_isize,
    output logic                     err_valid,
    output logic [1:0]               err_code
`ifdef GZIP_DEFRAMER_STATS_EN
    ,
    output logic [31:0]              stat_members,
    output logic [31:0]              stat_errors,
    output logic [31:0]              stat_payload_bytes
`endif
);
    localparam int            CW       = $clog2(CAP_BYTES + 1);
    localparam int            HDR_REM  = GZIP_HDR_BYTES - 8;
    localparam logic [CW-1:0] TRL_CNT  = CW'(GZIP_TRL_BYTES);
    localparam logic [CW-1:0] EMIT_AT  = CW'(GZIP_TRL_BYTES + 8);
    localparam logic [CW-1:0] FILL_MAX = CW'(CAP_BYTES - 8);

    deframer_state_t      state_q, state_d;
    gzip_err_t            err_code_q, err_code_d;
    logic                 hdr_beat_q, hdr_beat_d, final_q, final_d;
    logic                 src_valid_q, src_valid_d, src_last_q, src_last_d;
    logic [DATA_BITS-1:0] src_data_q, src_data_d;
    logic [7:0]           src_keep_q, src_keep_d;
    logic                 trl_valid_q, trl_valid_d, err_valid_q, err_valid_d;
    logic [31:0]          trl_crc_q, trl_crc_d, trl_isize_q, trl_isize_d;

    logic          st_clear, st_pop, st_push;
    logic [63:0]   st_push_data, oldest, newest;
    logic [7:0]    st_push_keep;
    logic [CW-1:0] count;
    logic          snk_ready, snk_fire, slot_free;
    logic [3:0]    hdr_miss;

    gzip_byte_stager #(.CAP_BYTES(CAP_BYTES)) u_stager (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (st_clear),
        .pop_i       (st_pop),
        .push_i      (st_push),
        .push_data_i (st_push_data),
        .push_keep_i (st_push_keep),
        .count_o     (count),
        .oldest_o    (oldest),
        .newest_o    (newest)
    );

    // Only header bytes actually present in a short beat are checked.
    assign hdr_miss = axis_snk.tkeep[3:0] & {axis_snk.tdata[31:24] != 8'h00,
                                             axis_snk.tdata[23:16] != GZIP_CM_DEFLATE,
                                             axis_snk.tdata[15:8]  != GZIP_ID2,
                                             axis_snk.tdata[7:0]   != GZIP_ID1};

    always_comb begin
        snk_ready = 1'b0;
        unique case (state_q)
            HDR, SKIP: snk_ready = 1'b1;
            BODY:      snk_ready = (count <= FILL_MAX) &&
                                   !((count >= EMIT_AT) && src_valid_q && !axis_src.tready);
            default:   snk_ready = 1'b0;
        endcase
    end

    assign snk_fire  = axis_snk.tvalid && snk_ready;
    assign slot_free = !src_valid_q || axis_src.tready;

    // The 8-byte holdback guarantees the trailer is never emitted; the final beat
    // does not pop so the trailer is still the newest 8 bytes at its handshake.
    always_comb begin
        state_d      = state_q;
        hdr_beat_d   = hdr_beat_q;
        final_d      = final_q;
        src_valid_d  = src_valid_q && !axis_src.tready;
        src_data_d   = src_data_q;
        src_keep_d   = src_keep_q;
        src_last_d   = src_last_q;
        trl_valid_d  = 1'b0;
        trl_crc_d    = trl_crc_q;
        trl_isize_d  = trl_isize_q;
        err_valid_d  = 1'b0;
        err_code_d   = err_code_q;
        st_clear     = 1'b0;
        st_pop       = 1'b0;
        st_push      = 1'b0;
        st_push_data = axis_snk.tdata;
        st_push_keep = axis_snk.tkeep;

        unique case (state_q)
            HDR: begin
                if (snk_fire && !hdr_beat_q) begin
                    if (|hdr_miss) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_BAD_HDR;
                        state_d     = axis_snk.tlast ? HDR : SKIP;
                    end else if (axis_snk.tlast) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_SHORT;
                    end else begin
                        hdr_beat_d = 1'b1;
                    end
                end else if (snk_fire) begin
                    hdr_beat_d = 1'b0;
                    if (!axis_snk.tkeep[HDR_REM-1]) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_SHORT;
                    end else begin
                        st_push      = |axis_snk.tkeep[7:HDR_REM];
                        st_push_data = axis_snk.tdata >> (HDR_REM * 8);
                        st_push_keep = axis_snk.tkeep >> HDR_REM;
                        state_d      = axis_snk.tlast ? FLUSH : BODY;
                    end
                end
            end
            BODY: begin
                if ((count >= EMIT_AT) && slot_free) begin
                    src_valid_d = 1'b1;
                    src_data_d  = oldest;
                    src_keep_d  = 8'hFF;
                    src_last_d  = 1'b0;
                    st_pop      = 1'b1;
                end
                if (snk_fire) begin
                    st_push = 1'b1;
                    if (axis_snk.tlast) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (final_q || (count == TRL_CNT)) begin
                    if (!final_q || (src_valid_q && axis_src.tready)) begin
                        trl_valid_d = 1'b1;
                        trl_crc_d   = newest[31:0];
                        trl_isize_d = newest[63:32];
                        st_clear    = 1'b1;
                        final_d     = 1'b0;
                        state_d     = HDR;
                    end
                end else if (count < TRL_CNT) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_SHORT;
                    st_clear    = 1'b1;
                    state_d     = HDR;
                end else if (slot_free) begin
                    src_valid_d = 1'b1;
                    src_data_d  = oldest;
                    if (count > EMIT_AT) begin
                        src_keep_d = 8'hFF;
                        src_last_d = 1'b0;
                        st_pop     = 1'b1;
                    end else begin
                        src_keep_d = byte_mask(4'(count - TRL_CNT));
                        src_last_d = 1'b1;
                        final_d    = 1'b1;
                    end
                end
            end
            SKIP: begin
                if (snk_fire && axis_snk.tlast) state_d = HDR;
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HDR;
            hdr_beat_q  <= 1'b0;
            final_q     <= 1'b0;
            src_valid_q <= 1'b0;
            src_data_q  <= '0;
            src_keep_q  <= '0;
            src_last_q  <= 1'b0;
            trl_valid_q <= 1'b0;
            trl_crc_q   <= '0;
            trl_isize_q <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            hdr_beat_q  <= hdr_beat_d;
            final_q     <= final_d;
            src_valid_q <= src_valid_d;
            src_data_q  <= src_data_d;
            src_keep_q  <= src_keep_d;
            src_last_q  <= src_last_d;
            trl_valid_q <= trl_valid_d;
            trl_crc_q   <= trl_crc_d;
            trl_isize_q <= trl_isize_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign axis_snk.tready = snk_ready;
    assign axis_src.tvalid = src_valid_q;
    assign axis_src.tdata  = src_data_q;
    assign axis_src.tkeep  = src_keep_q;
    assign axis_src.tlast  = src_last_q;
    assign trl_valid       = trl_valid_q;
    assign trl_crc32       = trl_crc_q;
    assign trl_isize       = trl_isize_q;
    assign err_valid       = err_valid_q;
    assign err_code        = err_code_q;

`ifdef GZIP_DEFRAMER_STATS_EN
    logic [31:0] stat_members_q, stat_errors_q, stat_bytes_q;
    logic [32:0] bytes_sum;

    assign bytes_sum = {1'b0, stat_bytes_q} + {29'd0, keep_bytes(src_keep_q)};

    // All counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_members_q <= '0;
            stat_errors_q  <= '0;
            stat_bytes_q   <= '0;
        end else begin
            if (trl_valid_q && (stat_members_q != '1)) stat_members_q <= stat_members_q + 32'd1;
            if (err_valid_q && (stat_errors_q != '1))  stat_errors_q  <= stat_errors_q + 32'd1;
            if (src_valid_q && axis_src.tready)        stat_bytes_q   <= bytes_sum[32] ? '1 : bytes_sum[31:0];
        end
    end

    assign stat_members       = stat_members_q;
    assign stat_errors        = stat_errors_q;
    assign stat_payload_bytes = stat_bytes_q;
`endif

endmodule

// File: tb/tb_gzip_member_deframer.sv
// Directed bench for gzip_member_deframer: header/trailer stripping, errors, backpressure, reset.
module tb_gzip_member_deframer;

   logic clk;
   logic rst_n;
   logic trlValid, errValid;
   logic [31:0] trlCrc, trlIsize;
   logic [1:0] errCode;
`ifdef GZIP_DEFRAMER_STATS_EN
   logic [31:0] statMembers, statErrors, statPayloadBytes;
`endif

   gzip_member_deframer_if snkIf ();
   gzip_member_deframer_if srcIf ();

   gzip_member_deframer dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .axis_snk           (snkIf),
      .axis_src           (srcIf),
      .trl_valid          (trlValid),
      .trl_crc32          (trlCrc),
      .trl_isize          (trlIsize),
      .err_valid          (errValid),
      .err_code           (errCode)
`ifdef GZIP_DEFRAMER_STATS_EN
      ,
      .stat_members       (statMembers),
      .stat_errors        (statErrors),
      .stat_payload_bytes (statPayloadBytes)
`endif
   );

   int assertions = 0;
   int failures = 0;
   int trlCount = 0;
   int errCount = 0;
   int stallErrors = 0;
   int timeouts = 0;
   bit randomReady = 0;
   bit stallPending = 0;
   logic [63:0] heldData;
   logic [7:0] heldKeep;
   logic heldLast;
   logic [7:0] pktBytes[$];
   logic [7:0] expBytes[$];
   logic [7:0] gotBytes[$];
   logic [7:0] gotKeep[$];
   logic gotLast[$];

   // Free-running clock.
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges beyond every bounded wait.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

   // Output-side ready: always high, or a fair coin per cycle when randomReady is set.
   initial begin
      srcIf.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         srcIf.tready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor on the falling edge: collects output beats, pulses and stall stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         stallPending = 0;
      end else begin
         if (stallPending && !(srcIf.tvalid && srcIf.tdata === heldData &&
                               srcIf.tkeep === heldKeep && srcIf.tlast === heldLast))
            stallErrors++;
         stallPending = srcIf.tvalid && !srcIf.tready;
         heldData = srcIf.tdata;
         heldKeep = srcIf.tkeep;
         heldLast = srcIf.tlast;
         if (srcIf.tvalid && srcIf.tready) begin
            gotKeep.push_back(srcIf.tkeep);
            gotLast.push_back(srcIf.tlast);
            for (int k = 0; k < 8; k++)
               if (srcIf.tkeep[k]) gotBytes.push_back(srcIf.tdata[k*8 +: 8]);
         end
         if (trlValid) trlCount++;
         if (errValid) errCount++;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertions++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic sendBeat(input logic [63:0] d, input logic [7:0] k, input logic l);
      int budget;
      budget = 0;
      snkIf.tdata = d;
      snkIf.tkeep = k;
      snkIf.tlast = l;
      snkIf.tvalid = 1'b1;
      do begin
         @(negedge clk);
         budget++;
      end while (!snkIf.tready && budget < 2000);
      if (!snkIf.tready) timeouts++;
      @(posedge clk);
      #1;
      snkIf.tvalid = 1'b0;
   endtask

   // Sends pktBytes as beats, stopping after maxBeats, optionally with idle gaps.
   task automatic applyStimulus(input bit gaps, input int maxBeats);
      int n, nb;
      logic [63:0] d;
      logic [7:0] k;
      n = pktBytes.size();
      nb = (n + 7) / 8;
      for (int b = 0; b < nb && b < maxBeats; b++) begin
         d = '0;
         k = '0;
         for (int j = 0; j < 8; j++)
            if (b * 8 + j < n) begin
               d[j*8 +: 8] = pktBytes[b*8 + j];
               k[j] = 1'b1;
            end
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         sendBeat(d, k, b == nb - 1);
      end
   endtask

   task automatic buildMember(input int plen, input logic [31:0] crc, input logic [31:0] isz,
                              input logic [7:0] id1, input logic [7:0] seed);
      logic [7:0] b;
      pktBytes.delete();
      expBytes.delete();
      pktBytes.push_back(id1);   pktBytes.push_back(8'h8B);
      pktBytes.push_back(8'h08); pktBytes.push_back(8'h00);
      pktBytes.push_back(8'h12); pktBytes.push_back(8'h34);
      pktBytes.push_back(8'h56); pktBytes.push_back(8'h78);
      pktBytes.push_back(8'h00); pktBytes.push_back(8'h03);
      for (int i = 0; i < plen; i++) begin
         b = 8'(i * 7 + (i >> 8) + 3) ^ seed;
         pktBytes.push_back(b);
         expBytes.push_back(b);
      end
      for (int i = 0; i < 4; i++) pktBytes.push_back(crc[i*8 +: 8]);
      for (int i = 0; i < 4; i++) pktBytes.push_back(isz[i*8 +: 8]);
   endtask

   task automatic clearGot();
      gotBytes.delete();
      gotKeep.delete();
      gotLast.delete();
   endtask

   task automatic waitDone(input int trlTarget, input int errTarget);
      int budget;
      budget = 0;
      while ((trlCount < trlTarget || errCount < errTarget) && budget < 3000) begin
         @(posedge clk);
         #1;
         budget++;
      end
      repeat (10) begin @(posedge clk); #1; end
   endtask

   task automatic checkPayload(input string tag);
      checkOutput({tag, "_bytes"}, 64'(gotBytes.size()), 64'(expBytes.size()));
      for (int i = 0; i < gotBytes.size() && i < expBytes.size(); i++)
         checkOutput({tag, "_byte"}, 64'(gotBytes[i]), 64'(expBytes[i]));
   endtask

   // Directed sequence; each step lists its hand-derived expectations.
   initial begin
      rst_n = 1'b0;
      snkIf.tvalid = 1'b0;
      snkIf.tdata = '0;
      snkIf.tkeep = '0;
      snkIf.tlast = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_src_tvalid", 64'(srcIf.tvalid), 64'd0);
      checkOutput("rst_trl_valid", 64'(trlValid), 64'd0);
      checkOutput("rst_trl_crc32", 64'(trlCrc), 64'd0);
      checkOutput("rst_trl_isize", 64'(trlIsize), 64'd0);
      checkOutput("rst_err_valid", 64'(errValid), 64'd0);
      checkOutput("rst_err_code", 64'(errCode), 64'd0);
      checkOutput("rst_snk_tready", 64'(snkIf.tready), 64'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] valid member, 20 payload bytes");
      clearGot();
      buildMember(20, 32'hCAFEF00D, 32'd20, 8'h1F, 8'h00);
      applyStimulus(0, 1000);
      waitDone(1, 0);
      checkOutput("t1_beats", 64'(gotKeep.size()), 64'd3);
      checkOutput("t1_keep0", 64'(gotKeep[0]), 64'hFF);
      checkOutput("t1_keep1", 64'(gotKeep[1]), 64'hFF);
      checkOutput("t1_keep2", 64'(gotKeep[2]), 64'h0F);
      checkOutput("t1_last0", 64'(gotLast[0]), 64'd0);
      checkOutput("t1_last1", 64'(gotLast[1]), 64'd0);
      checkOutput("t1_last2", 64'(gotLast[2]), 64'd1);
      checkPayload("t1");
      checkOutput("t1_crc32", 64'(trlCrc), 64'hCAFEF00D);
      checkOutput("t1_isize", 64'(trlIsize), 64'd20);
      checkOutput("t1_trl_count", 64'(trlCount), 64'd1);
      checkOutput("t1_err_count", 64'(errCount), 64'd0);

      $display("[TB] minimal 18-byte member");
      clearGot();
      buildMember(0, 32'h01234567, 32'h89ABCDEF, 8'h1F, 8'h00);
      applyStimulus(0, 1000);
      waitDone(2, 0);
      checkOutput("t2_beats", 64'(gotKeep.size()), 64'd0);
      checkOutput("t2_crc32", 64'(trlCrc), 64'h01234567);
      checkOutput("t2_isize", 64'(trlIsize), 64'h89ABCDEF);
      checkOutput("t2_trl_count", 64'(trlCount), 64'd2);

      $display("[TB] bad ID1 then valid member");
      clearGot();
      buildMember(22, 32'hDEADBEEF, 32'd22, 8'h1E, 8'h00);
      applyStimulus(0, 1000);
      waitDone(2, 1);
      checkOutput("t3_err_count", 64'(errCount), 64'd1);
      checkOutput("t3_err_code", 64'(errCode), 64'd1);
      checkOutput("t3_trl_count", 64'(trlCount), 64'd2);
      checkOutput("t3_beats", 64'(gotKeep.size()), 64'd0);
      buildMember(12, 32'h0BADCAFE, 32'd12, 8'h1F, 8'h5A);
      applyStimulus(0, 1000);
      waitDone(3, 1);
      checkOutput("t3b_beats", 64'(gotKeep.size()), 64'd2);
      checkOutput("t3b_keep1", 64'(gotKeep[1]), 64'h0F);
      checkOutput("t3b_last1", 64'(gotLast[1]), 64'd1);
      checkPayload("t3b");
      checkOutput("t3b_crc32", 64'(trlCrc), 64'h0BADCAFE);

      $display("[TB] 14-byte packet");
      clearGot();
      buildMember(0, 32'h11111111, 32'h22222222, 8'h1F, 8'h00);
      repeat (4) void'(pktBytes.pop_back());
      applyStimulus(0, 1000);
      waitDone(3, 2);
      checkOutput("t4_err_count", 64'(errCount), 64'd2);
      checkOutput("t4_err_code", 64'(errCode), 64'd2);
      checkOutput("t4_trl_count", 64'(trlCount), 64'd3);
      checkOutput("t4_beats", 64'(gotKeep.size()), 64'd0);
      checkOutput("t4_crc32_held", 64'(trlCrc), 64'h0BADCAFE);

      $display("[TB] 1 KiB payload with backpressure and gaps");
      clearGot();
      randomReady = 1;
      buildMember(1024, 32'hA5A5C3C3, 32'd1024, 8'h1F, 8'h3C);
      applyStimulus(1, 1000);
      waitDone(4, 2);
      randomReady = 0;
      checkPayload("t5");
      checkOutput("t5_beats", 64'(gotKeep.size()), 64'd128);
      checkOutput("t5_last_keep", 64'(gotKeep[127]), 64'hFF);
      checkOutput("t5_last_flag", 64'(gotLast[127]), 64'd1);
      checkOutput("t5_stall_stable", 64'(stallErrors), 64'd0);
      checkOutput("t5_crc32", 64'(trlCrc), 64'hA5A5C3C3);
      checkOutput("t5_isize", 64'(trlIsize), 64'd1024);

      $display("[TB] reset mid-member then fresh member");
      buildMember(16, 32'h33333333, 32'd16, 8'h1F, 8'h77);
      applyStimulus(0, 3);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("t6_rst_crc32", 64'(trlCrc), 64'd0);
      checkOutput("t6_rst_tvalid", 64'(srcIf.tvalid), 64'd0);
      checkOutput("t6_rst_err_code", 64'(errCode), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      clearGot();
      buildMember(16, 32'h44444444, 32'd16, 8'h1F, 8'h99);
      applyStimulus(0, 1000);
      waitDone(5, 2);
      checkPayload("t6");
      checkOutput("t6_beats", 64'(gotKeep.size()), 64'd2);
      checkOutput("t6_last_keep", 64'(gotKeep[1]), 64'hFF);
      checkOutput("t6_crc32", 64'(trlCrc), 64'h44444444);
`ifdef GZIP_DEFRAMER_STATS_EN
      checkOutput("t6_stat_members", 64'(statMembers), 64'd1);
      checkOutput("t6_stat_payload", 64'(statPayloadBytes), 64'd16);
`endif

      checkOutput("handshake_timeouts", 64'(timeouts), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
